// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default sizing for the two-master data-memory arbiter.
package data_mem_arbiter_pkg;

  typedef enum logic {
    MASTER_CORE = 1'b0,
    MASTER_AUX  = 1'b1
  } mem_master_e;

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/data_mem_arbiter_arb_id_fifo.sv
// Small synchronous FIFO holding the issuing-master ID of each granted request.
module data_mem_arbiter_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come from the registered count, so a pop frees a slot only next cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU and an aux master;
// responses are routed back by an in-order ID FIFO.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_err_o,

  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_err_o,

  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i,

  output logic                    protocol_err_o
);

  mem_master_e sel_q, sel_d;
  mem_master_e lock_sel_q, lock_sel_d;
  mem_master_e arb_sel, cur_sel, head_sel;
  logic        lock_q, lock_d;
  logic        perr_q, perr_d;
  logic        sel_req, grant;
  logic        fifo_full, fifo_empty, fifo_pop, fifo_head;

  // Round-robin on conflict; a stalled request keeps its master until granted.
  always_comb begin
    arb_sel = sel_q;
    if (m0_req_i && m1_req_i) arb_sel = (sel_q == MASTER_CORE) ? MASTER_AUX : MASTER_CORE;
    else if (m0_req_i)        arb_sel = MASTER_CORE;
    else if (m1_req_i)        arb_sel = MASTER_AUX;
    cur_sel = lock_q ? lock_sel_q : arb_sel;
  end

  assign sel_req   = (cur_sel == MASTER_CORE) ? m0_req_i : m1_req_i;
  assign mem_req_o = sel_req & ~fifo_full;
  assign grant     = mem_req_o & mem_gnt_i;
  assign m0_gnt_o  = grant & (cur_sel == MASTER_CORE);
  assign m1_gnt_o  = grant & (cur_sel == MASTER_AUX);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (cur_sel == MASTER_CORE) begin
        mem_addr_o  = m0_addr_i;
        mem_we_o    = m0_we_i;
        mem_be_o    = m0_be_i;
        mem_wdata_o = m0_wdata_i;
      end else begin
        mem_addr_o  = m1_addr_i;
        mem_we_o    = m1_we_i;
        mem_be_o    = m1_be_i;
        mem_wdata_o = m1_wdata_i;
      end
    end
  end

  assign fifo_pop = mem_rvalid_i & ~fifo_empty;
  assign head_sel = mem_master_e'(fifo_head);

  always_comb begin
    m0_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m0_err_o    = 1'b0;
    m1_rvalid_o = 1'b0;
    m1_rdata_o  = '0;
    m1_err_o    = 1'b0;
    if (fifo_pop) begin
      if (head_sel == MASTER_CORE) begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = mem_rdata_i;
        m0_err_o    = mem_err_i;
      end else begin
        m1_rvalid_o = 1'b1;
        m1_rdata_o  = mem_rdata_i;
        m1_err_o    = mem_err_i;
      end
    end
  end

  data_mem_arbiter_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (cur_sel),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    sel_d      = grant ? cur_sel : sel_q;
    lock_d     = mem_req_o & ~mem_gnt_i;
    lock_sel_d = cur_sel;
    perr_d     = perr_q | (mem_rvalid_i & fifo_empty);
  end

  // sel_q resets to the aux master so the core wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q      <= MASTER_AUX;
      lock_q     <= 1'b0;
      lock_sel_q <= MASTER_CORE;
      perr_q     <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      perr_q     <= perr_d;
    end
  end

  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus a randomized phase, all checked
// against a transaction-level model (outstanding-ID queue, last-granted master, stalled request).
module tb_data_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          req   [2];
  logic [AW-1:0] addr  [2];
  logic          we    [2];
  logic [BW-1:0] be    [2];
  logic [DW-1:0] wdata [2];

  logic          gnt0, gnt1, rv0, rv1, err0, err1;
  logic [DW-1:0] rd0, rd1;
  logic          mem_req, mem_gnt, mem_rvalid, mem_we, mem_err, perr;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int q[$];
  int last_g = 1;
  bit pend_v = 1'b0;
  int pend_m = 0;
  bit perr_m = 1'b0;
  bit g_exp [2];

  data_mem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .m0_req_i       (req[0]),
    .m0_gnt_o       (gnt0),
    .m0_rvalid_o    (rv0),
    .m0_addr_i      (addr[0]),
    .m0_we_i        (we[0]),
    .m0_be_i        (be[0]),
    .m0_wdata_i     (wdata[0]),
    .m0_rdata_o     (rd0),
    .m0_err_o       (err0),
    .m1_req_i       (req[1]),
    .m1_gnt_o       (gnt1),
    .m1_rvalid_o    (rv1),
    .m1_addr_i      (addr[1]),
    .m1_we_i        (we[1]),
    .m1_be_i        (be[1]),
    .m1_wdata_i     (wdata[1]),
    .m1_rdata_o     (rd1),
    .m1_err_o       (err1),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_addr_o     (mem_addr),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .mem_err_i      (mem_err),
    .protocol_err_o (perr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; addr[m] = '0; we[m] = 1'b0; be[m] = '0; wdata[m] = '0;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    q.delete();
    pend_v = 1'b0; last_g = 1; perr_m = 1'b0;
    g_exp[0] = 1'b0; g_exp[1] = 1'b0;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m0_gnt", gnt0, 0);
    chk("rst_m1_gnt", gnt1, 0);
    chk("rst_m0_rvalid", rv0, 0);
    chk("rst_m1_rvalid", rv1, 0);
    chk("rst_perr", perr, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // Inputs are set at posedge+1; outputs are compared at posedge+4, then the model commits.
  task automatic step();
    int sel, head;
    bit ereq, egnt, epop, was_empty;
    #3;
    if (pend_v)                 sel = pend_m;
    else if (req[0] && req[1])  sel = 1 - last_g;
    else if (req[1])            sel = 1;
    else if (req[0])            sel = 0;
    else                        sel = last_g;
    was_empty = (q.size() == 0);
    ereq = req[sel] && (q.size() < MAXO);
    egnt = ereq && mem_gnt;
    epop = mem_rvalid && !was_empty;
    head = epop ? q[0] : -1;

    chk("mem_req", mem_req, ereq);
    chk("mem_addr", mem_addr, ereq ? addr[sel] : 0);
    chk("mem_we", mem_we, ereq ? we[sel] : 0);
    chk("mem_be", mem_be, ereq ? be[sel] : 0);
    chk("mem_wdata", mem_wdata, ereq ? wdata[sel] : 0);
    chk("m0_gnt", gnt0, egnt && sel == 0);
    chk("m1_gnt", gnt1, egnt && sel == 1);
    chk("m0_rvalid", rv0, head == 0);
    chk("m1_rvalid", rv1, head == 1);
    chk("m0_rdata", rd0, (head == 0) ? mem_rdata : 0);
    chk("m1_rdata", rd1, (head == 1) ? mem_rdata : 0);
    chk("m0_err", err0, (head == 0) ? mem_err : 0);
    chk("m1_err", err1, (head == 1) ? mem_err : 0);
    chk("protocol_err", perr, perr_m);

    g_exp[0] = egnt && sel == 0;
    g_exp[1] = egnt && sel == 1;
    @(posedge clk_i); #1;
    if (epop) void'(q.pop_front());
    if (egnt) begin q.push_back(sel); last_g = sel; end
    pend_v = ereq && !mem_gnt;
    pend_m = sel;
    if (mem_rvalid && was_empty) perr_m = 1'b1;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic w,
                         input logic [BW-1:0] b, input logic [DW-1:0] d);
    req[m] = 1'b1; addr[m] = a; we[m] = w; be[m] = b; wdata[m] = d;
  endtask

  task automatic drain();
    req[0] = 1'b0; req[1] = 1'b0; mem_gnt = 1'b0;
    for (int i = 0; i < MAXO + 1; i++) begin
      mem_rvalid = (q.size() > 0);
      mem_rdata  = $urandom;
      mem_err    = 1'($urandom_range(0, 1));
      step();
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    clear_inputs();
    @(posedge clk_i); #1;
    do_reset();

    // Single core read, granted at once, response next cycle.
    set_req(0, 32'h100, 1'b0, 4'hF, 32'h0);
    mem_gnt = 1'b1;
    step();
    req[0] = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; mem_err = 1'b0;
    step();
    mem_rvalid = 1'b0;
    step();

    // Both masters requesting from reset: alternate grants, responses in issue order.
    do_reset();
    set_req(0, 32'h200, 1'b0, 4'hF, 32'h0);
    set_req(1, 32'h300, 1'b0, 4'hF, 32'h0);
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i > 0);
      mem_rdata  = 32'hA000_0000 + i;
      step();
    end
    drain();

    // Memory stalls the core; aux arrives mid-stall and waits its turn.
    set_req(0, 32'h400, 1'b0, 4'hF, 32'h0);
    mem_gnt = 1'b0;
    step();
    set_req(1, 32'h500, 1'b1, 4'h3, 32'h1234);
    step();
    step();
    mem_gnt = 1'b1;
    step();
    req[0] = 1'b0;
    step();
    drain();

    // FIFO full blocks the request; one response reopens it a cycle later.
    set_req(0, 32'h600, 1'b0, 4'hF, 32'h0);
    mem_gnt = 1'b1;
    step();
    step();
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    mem_rvalid = 1'b0;
    step();
    drain();

    // Aux write with error response.
    set_req(1, 32'h2000, 1'b1, 4'b0011, 32'h0000ABCD);
    mem_gnt = 1'b1;
    step();
    req[1] = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0; mem_err = 1'b1;
    step();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    step();

    // Randomized traffic: a master holds its request fields until granted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] || g_exp[m]) begin
          req[m]   = ($urandom_range(0, 2) != 0);
          addr[m]  = $urandom;
          we[m]    = 1'($urandom_range(0, 1));
          be[m]    = BW'($urandom);
          wdata[m] = $urandom;
        end
      end
      mem_gnt    = 1'($urandom_range(0, 1));
      mem_rvalid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata  = $urandom;
      mem_err    = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Reset with one transaction outstanding; the late response is not forwarded.
    do_reset();
    set_req(0, 32'h700, 1'b0, 4'hF, 32'h0);
    mem_gnt = 1'b1;
    step();
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'hBADC0DE5; mem_err = 1'b1;
    step();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
